// File: rtl/fb_pkg.sv
// Shared frame-buffer sizing and fill-state encoding for the frame write path.
package fb_pkg;
   localparam int DATA_WIDTH = 12;
   localparam int ADDR_WIDTH = 15;
   localparam int NPIX       = 19200;

   localparam logic [0:0] FILL_IDLE = 1'b0;
   localparam logic [0:0] FILL_FILL = 1'b1;
endpackage

// File: rtl/fill_engine.sv
// Whole-frame fill sequencer: issues one write per unstalled cycle from
// address 0 to NPIX-1 using a colour latched at start.
module fill_engine #(
   parameter int DATA_WIDTH = fb_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
   parameter int NPIX       = fb_pkg::NPIX
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [DATA_WIDTH-1:0] i_color,
   input  logic                  i_stall,
   output logic                  o_busy,
   output logic                  o_we,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [DATA_WIDTH-1:0] o_data
);
   import fb_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NPIX - 1);

   logic [0:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [DATA_WIDTH-1:0] r_color;
   logic                  w_we;

   // Write request only; the top-level arbiter stalls us when a higher source wins.
   assign w_we   = (r_state == FILL_FILL) && !i_stall;
   assign o_we   = w_we;
   assign o_addr = r_cnt;
   assign o_data = r_color;
   assign o_busy = (r_state == FILL_FILL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FILL_IDLE;
         r_cnt   <= '0;
         r_color <= '0;
      end else if (r_state == FILL_IDLE) begin
         if (i_start) begin
            r_color <= i_color;
            r_cnt   <= '0;
            r_state <= FILL_FILL;
         end
      end else if (w_we) begin
         if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= FILL_IDLE;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/frame_write_ctrl.sv
// Frame-buffer write arbiter: camera stream > CPU single writes > frame fill,
// with a registered write port toward the buffer.
module frame_write_ctrl #(
   parameter int DATA_WIDTH = fb_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
   parameter int NPIX       = fb_pkg::NPIX
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_cam_vsync,
   input  logic                  i_cam_valid,
   input  logic [DATA_WIDTH-1:0] i_cam_data,
   input  logic                  i_cpu_req,
   input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
   input  logic [DATA_WIDTH-1:0] i_cpu_data,
   output logic                  o_cpu_ack,
   output logic                  o_cpu_err,
   input  logic                  i_fill_start,
   input  logic [DATA_WIDTH-1:0] i_fill_color,
   output logic                  o_fill_busy,
   output logic                  o_frame_done,
   output logic                  o_cam_drop,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_data
);
   import fb_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] NPIX_A = ADDR_WIDTH'(NPIX);
   localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(NPIX - 1);

   logic [ADDR_WIDTH-1:0] r_cam_cnt;
   logic [ADDR_WIDTH-1:0] w_cam_idx;
   logic                  w_cam_we;
   logic                  w_cpu_grant;
   logic                  w_cpu_ok;
   logic                  w_cpu_we;
   logic                  r_cpu_ack_d;
   logic                  w_fill_we;
   logic [ADDR_WIDTH-1:0] w_fill_addr;
   logic [DATA_WIDTH-1:0] w_fill_data;

   // vsync restarts the frame in the same cycle, so a coincident pixel lands at 0.
   assign w_cam_idx = i_cam_vsync ? '0 : r_cam_cnt;
   assign w_cam_we  = i_cam_valid && (w_cam_idx < NPIX_A);

   // r_cpu_ack_d blocks a second ack while the requester is still lowering cpu_req.
   assign w_cpu_grant = i_cpu_req && !w_cam_we && !r_cpu_ack_d && !rst;
   assign w_cpu_ok    = (i_cpu_addr < NPIX_A);
   assign w_cpu_we    = w_cpu_grant && w_cpu_ok;
   assign o_cpu_ack   = w_cpu_grant;

   fill_engine #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NPIX       (NPIX)
   ) u_fill (
      .clk     (clk),
      .rst     (rst),
      .i_start (i_fill_start),
      .i_color (i_fill_color),
      .i_stall (w_cam_we || w_cpu_grant),
      .o_busy  (o_fill_busy),
      .o_we    (w_fill_we),
      .o_addr  (w_fill_addr),
      .o_data  (w_fill_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cam_cnt    <= '0;
         o_frame_done <= 1'b0;
         o_cam_drop   <= 1'b0;
      end else begin
         o_frame_done <= w_cam_we && (w_cam_idx == LAST_A);
         if (w_cam_we)
            r_cam_cnt <= w_cam_idx + 1'b1;
         else if (i_cam_vsync)
            r_cam_cnt <= '0;
         if (i_cam_vsync)
            o_cam_drop <= 1'b0;
         else if (i_cam_valid && !w_cam_we)
            o_cam_drop <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cpu_ack_d <= 1'b0;
         o_cpu_err   <= 1'b0;
      end else begin
         r_cpu_ack_d <= w_cpu_grant;
         if (w_cpu_grant && !w_cpu_ok)
            o_cpu_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_mem_we   <= 1'b0;
         o_mem_addr <= '0;
         o_mem_data <= '0;
      end else begin
         o_mem_we <= w_cam_we || w_cpu_we || w_fill_we;
         if (w_cam_we) begin
            o_mem_addr <= w_cam_idx;
            o_mem_data <= i_cam_data;
         end else if (w_cpu_we) begin
            o_mem_addr <= i_cpu_addr;
            o_mem_data <= i_cpu_data;
         end else if (w_fill_we) begin
            o_mem_addr <= w_fill_addr;
            o_mem_data <= w_fill_data;
         end
      end
   end
endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed bench for frame_write_ctrl: a per-cycle vector table for arbitration
// and handshakes, plus full-frame camera, full fill and reset-abort sequences.
module tb_frame_write_ctrl;
   localparam int DW   = 12;
   localparam int AW   = 15;
   localparam int NPIX = 19200;

   logic          clk = 1'b0;
   logic          rst;
   logic          cam_vsync, cam_valid, cpu_req, fill_start;
   logic [DW-1:0] cam_data, cpu_data, fill_color;
   logic [AW-1:0] cpu_addr;
   logic          cpu_ack, cpu_err, fill_busy, frame_done, cam_drop, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   frame_write_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .i_cam_vsync  (cam_vsync),
      .i_cam_valid  (cam_valid),
      .i_cam_data   (cam_data),
      .i_cpu_req    (cpu_req),
      .i_cpu_addr   (cpu_addr),
      .i_cpu_data   (cpu_data),
      .o_cpu_ack    (cpu_ack),
      .o_cpu_err    (cpu_err),
      .i_fill_start (fill_start),
      .i_fill_color (fill_color),
      .o_fill_busy  (fill_busy),
      .o_frame_done (frame_done),
      .o_cam_drop   (cam_drop),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_data   (mem_data)
   );

   typedef struct {
      logic          vs, cv;
      logic [DW-1:0] cd;
      logic          rq;
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      logic          fs;
      logic [DW-1:0] fc;
      logic          ack, we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          done, drop, err, busy;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic addv(input int vs, input int cv, input int cd, input int rq, input int ra,
                       input int rd, input int fs, input int fc, input int ack, input int we,
                       input int addr, input int data, input int done, input int drop,
                       input int err, input int busy);
      vec_t v;
      v.vs = (vs != 0); v.cv = (cv != 0); v.cd = DW'(cd);
      v.rq = (rq != 0); v.ra = AW'(ra); v.rd = DW'(rd);
      v.fs = (fs != 0); v.fc = DW'(fc);
      v.ack = (ack != 0); v.we = (we != 0); v.addr = AW'(addr); v.data = DW'(data);
      v.done = (done != 0); v.drop = (drop != 0); v.err = (err != 0); v.busy = (busy != 0);
      vecs.push_back(v);
   endtask

   task automatic drive(input int vs, input int cv, input int cd, input int rq, input int ra,
                        input int rd, input int fs, input int fc);
      cam_vsync  = (vs != 0);
      cam_valid  = (cv != 0);
      cam_data   = DW'(cd);
      cpu_req    = (rq != 0);
      cpu_addr   = AW'(ra);
      cpu_data   = DW'(rd);
      fill_start = (fs != 0);
      fill_color = DW'(fc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string name, input int addr, input int data);
      chk({name, ".we"},   32'(mem_we),   32'd1);
      chk({name, ".addr"}, 32'(mem_addr), 32'(addr));
      chk({name, ".data"}, 32'(mem_data), 32'(data));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int done_cnt;
      int busy_cnt;

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("rst.mem_we", 32'(mem_we), 32'd0);
      chk("rst.mem_addr", 32'(mem_addr), 32'd0);
      chk("rst.mem_data", 32'(mem_data), 32'd0);
      chk("rst.cpu_ack", 32'(cpu_ack), 32'd0);
      chk("rst.flags", 32'({cpu_err, fill_busy, frame_done, cam_drop}), 32'd0);
      rst = 1'b0;

      //   vs cv cd     rq ra     rd     fs fc      ack we addr   data   dn dr er bs
      addv(0, 0, 0,     0, 0,     0,     0, 0,      0, 0, 0,     0,     0, 0, 0, 0);
      addv(1, 1, 'h111, 1, 'h100, 'h0AB, 0, 0,      0, 1, 0,     'h111, 0, 0, 0, 0);
      addv(0, 1, 'h222, 1, 'h100, 'h0AB, 0, 0,      0, 1, 1,     'h222, 0, 0, 0, 0);
      addv(0, 1, 'h333, 1, 'h100, 'h0AB, 0, 0,      0, 1, 2,     'h333, 0, 0, 0, 0);
      addv(0, 0, 0,     1, 'h100, 'h0AB, 0, 0,      1, 1, 'h100, 'h0AB, 0, 0, 0, 0);
      addv(0, 0, 0,     0, 0,     0,     0, 0,      0, 0, 0,     0,     0, 0, 0, 0);
      addv(0, 0, 0,     1, 5,     'h055, 0, 0,      1, 1, 5,     'h055, 0, 0, 0, 0);
      addv(0, 0, 0,     1, 5,     'h055, 0, 0,      0, 0, 0,     0,     0, 0, 0, 0);
      addv(0, 0, 0,     0, 0,     0,     0, 0,      0, 0, 0,     0,     0, 0, 0, 0);
      addv(0, 0, 0,     1, 19200, 'h777, 0, 0,      1, 0, 0,     0,     0, 0, 1, 0);
      addv(0, 0, 0,     0, 0,     0,     0, 0,      0, 0, 0,     0,     0, 0, 1, 0);
      addv(0, 0, 0,     1, 19199, 'h0CC, 0, 0,      1, 1, 19199, 'h0CC, 0, 0, 1, 0);
      addv(0, 0, 0,     0, 0,     0,     0, 0,      0, 0, 0,     0,     0, 0, 1, 0);
      addv(0, 0, 0,     0, 0,     0,     1, 'h0F0,  0, 0, 0,     0,     0, 0, 1, 1);
      addv(0, 0, 0,     1, 7,     'h077, 0, 0,      1, 1, 7,     'h077, 0, 0, 1, 1);
      addv(0, 0, 0,     0, 0,     0,     0, 0,      0, 1, 0,     'h0F0, 0, 0, 1, 1);
      addv(0, 1, 'h444, 0, 0,     0,     0, 0,      0, 1, 3,     'h444, 0, 0, 1, 1);
      addv(0, 0, 0,     0, 0,     0,     0, 0,      0, 1, 1,     'h0F0, 0, 0, 1, 1);
      addv(0, 0, 0,     0, 0,     0,     1, 'h00F,  0, 1, 2,     'h0F0, 0, 0, 1, 1);
      addv(0, 0, 0,     0, 0,     0,     0, 0,      0, 1, 3,     'h0F0, 0, 0, 1, 1);

      foreach (vecs[k]) begin
         vec_t v;
         string nm;
         v  = vecs[k];
         nm = $sformatf("vec%0d", k);
         drive(int'(v.vs), int'(v.cv), int'(v.cd), int'(v.rq), int'(v.ra), int'(v.rd),
               int'(v.fs), int'(v.fc));
         #1;
         chk({nm, ".ack"}, 32'(cpu_ack), 32'(v.ack));
         tick();
         chk({nm, ".we"}, 32'(mem_we), 32'(v.we));
         if (v.we) begin
            chk({nm, ".addr"}, 32'(mem_addr), 32'(v.addr));
            chk({nm, ".data"}, 32'(mem_data), 32'(v.data));
         end
         chk({nm, ".flags"}, 32'({frame_done, cam_drop, cpu_err, fill_busy}),
             32'({v.done, v.drop, v.err, v.busy}));
      end

      // reset mid-fill aborts immediately and clears sticky state
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk("abort.we", 32'(mem_we), 32'd0);
      chk("abort.busy_err", 32'({fill_busy, cpu_err}), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("abort.idle_we", 32'(mem_we), 32'd0);

      // full camera frame
      done_cnt = 0;
      for (int i = 0; i < NPIX; i++) begin
         drive((i == 0) ? 1 : 0, 1, (i * 7 + 3) & 'hFFF, 0, 0, 0, 0, 0);
         tick();
         chk_wr("frame", i, (i * 7 + 3) & 'hFFF);
         chk("frame.done", 32'(frame_done), 32'(i == NPIX - 1));
         chk("frame.drop", 32'(cam_drop), 32'd0);
         if (frame_done) done_cnt++;
      end
      chk("frame.done_count", 32'(done_cnt), 32'd1);

      drive(0, 1, 'hABC, 0, 0, 0, 0, 0);
      tick();
      chk("overflow.we", 32'(mem_we), 32'd0);
      chk("overflow.drop", 32'(cam_drop), 32'd1);
      chk("overflow.done", 32'(frame_done), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("overflow.drop_sticky", 32'(cam_drop), 32'd1);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("vsync.drop_clear", 32'(cam_drop), 32'd0);
      chk("vsync.we", 32'(mem_we), 32'd0);

      // vsync mid-frame restarts at 0 with no frame_done
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 'h500 + i, 0, 0, 0, 0, 0);
         tick();
         chk_wr("midvs.pre", i, 'h500 + i);
      end
      drive(1, 1, 'h5AA, 0, 0, 0, 0, 0);
      tick();
      chk_wr("midvs.restart", 0, 'h5AA);
      chk("midvs.done", 32'(frame_done), 32'd0);
      drive(0, 1, 'h5BB, 0, 0, 0, 0, 0);
      tick();
      chk_wr("midvs.next", 1, 'h5BB);

      // full-frame fill
      drive(0, 0, 0, 0, 0, 0, 1, 'hF00);
      tick();
      chk("fill.start_busy", 32'(fill_busy), 32'd1);
      chk("fill.start_we", 32'(mem_we), 32'd0);
      busy_cnt = 1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < NPIX; i++) begin
         tick();
         chk_wr("fill", i, 'hF00);
         chk("fill.busy", 32'(fill_busy), 32'(i != NPIX - 1));
         if (fill_busy) busy_cnt++;
      end
      chk("fill.busy_cycles", 32'(busy_cnt), 32'(NPIX));
      tick();
      chk("fill.after_we", 32'(mem_we), 32'd0);

      // reset at fill index 500, then a fresh fill restarts from 0
      drive(0, 0, 0, 0, 0, 0, 1, 'h123);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 500; i++) begin
         tick();
         chk_wr("fill500", i, 'h123);
      end
      rst = 1'b1;
      #1;
      chk("rst500.we", 32'(mem_we), 32'd0);
      chk("rst500.busy", 32'(fill_busy), 32'd0);
      tick();
      chk("rst500.we_held", 32'(mem_we), 32'd0);
      rst = 1'b0;
      tick();
      chk("rst500.idle", 32'({mem_we, fill_busy}), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 1, 'h0AA);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk_wr("refill0", 0, 'h0AA);
      tick();
      chk_wr("refill1", 1, 'h0AA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/frame_write_ctrl.md
FRAME_WRITE_CTRL -- requirements
Module: frame_write_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 12, meaning the RGB444 pixel width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 15, meaning the frame-buffer address width.
REQ-003 The block SHALL have parameter NPIX, default 19200, meaning the pixels per frame (160x120).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cam_vsync  in  1  start-of-frame strobe from the camera capture stage.
REQ-007 cam_valid  in  1  camera pixel valid; no backpressure exists for this port.
REQ-008 cam_data  in  DATA_WIDTH  camera pixel.
REQ-009 cpu_req  in  1  CPU single-pixel write request, held high until cpu_ack.
REQ-010 cpu_addr  in  ADDR_WIDTH  CPU pixel address.
REQ-011 cpu_data  in  DATA_WIDTH  CPU pixel value.
REQ-012 cpu_ack  out  1  one-cycle grant pulse for the CPU request.
REQ-013 cpu_err  out  1  sticky flag: CPU address was >= NPIX.
REQ-014 fill_start  in  1  pulse that starts a whole-frame fill.
REQ-015 fill_color  in  DATA_WIDTH  fill value, sampled on fill_start.
REQ-016 fill_busy  out  1  high while the fill is in progress.
REQ-017 frame_done  out  1  one-cycle pulse when camera pixel NPIX-1 is written.
REQ-018 cam_drop  out  1  sticky flag: camera pixel received after NPIX pixels in a frame.
REQ-019 mem_we, mem_addr, mem_data  out  1/ADDR_WIDTH/DATA_WIDTH  write port toward the frame buffer.

Function
REQ-020 The write port SHALL grant at most one source per cycle, with fixed priority camera > CPU > fill.
REQ-021 mem_we/mem_addr/mem_data SHALL be registered, so a write appears exactly 1 cycle after the granting input cycle.
REQ-022 The camera address counter SHALL reset to 0 on cam_vsync; cam_vsync with cam_valid in the same cycle SHALL write that pixel to address 0, leaving the counter at 1.
REQ-023 Each cam_valid with counter < NPIX SHALL write cam_data at the counter value and increment the counter; at counter = NPIX-1, frame_done SHALL pulse together with that write.
REQ-024 cam_valid with counter = NPIX SHALL produce no write and SHALL set cam_drop; the counter saturates at NPIX.
REQ-025 cam_vsync mid-frame SHALL restart at address 0 without pulsing frame_done.
REQ-026 CPU handshake: while cpu_req=1 and the camera is idle that cycle, cpu_ack SHALL pulse for one cycle; the write occurs only if cpu_addr < NPIX, else cpu_err is set and no write occurs.
REQ-027 cpu_ack SHALL never pulse on consecutive cycles for one request; the requester drops or updates cpu_req after ack.
REQ-028 Fill FSM states: IDLE, FILL. fill_start in IDLE SHALL latch fill_color, clear the fill counter to 0, and enter FILL.
REQ-029 In FILL, each cycle without a camera or CPU grant SHALL write the latched color at the fill counter and increment it; the write of NPIX-1 returns to IDLE.
REQ-030 fill_start during FILL SHALL be ignored.
REQ-031 fill_busy SHALL be high in FILL and deasserted on the cycle after the final fill write is issued.
REQ-032 Counters SHALL be ADDR_WIDTH bits with compare against NPIX, never wrapping through 2^ADDR_WIDTH.

Reset
REQ-033 rst SHALL force: FSM to IDLE; both counters to 0; mem_we, cpu_ack, fill_busy, frame_done, cam_drop, cpu_err to 0; mem_addr and mem_data to 0.
REQ-034 rst mid-fill or mid-frame SHALL abort with no further writes; no partial state survives.
REQ-035 Sticky flags SHALL clear only on rst; cam_drop SHALL additionally clear on cam_vsync.

Structure
REQ-036 DATA_WIDTH, ADDR_WIDTH, NPIX, and the fill-state encoding SHALL live in a shared package, fb_pkg.
REQ-037 One sub-module, fill_engine (fill FSM plus counter with a stall input), SHALL be instantiated; arbitration and the camera path stay top-level.

Verification
REQ-038 vsync, then 19200 back-to-back cam_valid -> addresses 0..19199 written, frame_done once with the last write, cam_drop=0.
REQ-039 19201st cam_valid -> no mem_we, cam_drop=1; next cam_vsync clears cam_drop.
REQ-040 fill_start with color 0xF00 and camera idle -> 19200 writes of 0xF00 at addresses 0..19199 on consecutive cycles; fill_busy high for 19200 cycles.
REQ-041 cpu_req (addr 0x0100, data 0x0AB) asserted together with cam_valid for 3 cycles -> cpu_ack on cycle 4, write 0x0AB at 0x0100 on cycle 5.
REQ-042 cpu_addr 19200 -> cpu_ack pulses, no mem_we, cpu_err=1.
REQ-043 rst asserted at fill index 500 -> mem_we low from the next edge, fill_busy=0; a new fill restarts at address 0.
